axil_burst_master: RTL and testbench

AXIL_BURST_MASTER -- requirements
Module: axil_burst_master

---
 rtl/axil_burst_pkg.sv | 29 ++
 rtl/axil_word_buf.sv | 28 ++
 rtl/axil_burst_master.sv | 195 +++++++++++++++++++
 tb/tb_axil_burst_master.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_burst_pkg.sv
// Shared types and encodings for the AXI4-Lite burst master.
// FSM state enum, command mode codes and AXI response constants.
package axil_burst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW_W = 3'd3,
    ST_B    = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam logic [1:0] MODE_NOP  = 2'b00;
  localparam logic [1:0] MODE_WR   = 2'b01;
  localparam logic [1:0] MODE_RD   = 2'b10;
  localparam logic [1:0] MODE_COPY = 2'b11;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  function automatic logic mode_has_rd(input logic [1:0] m);
    return (m == MODE_RD) || (m == MODE_COPY);
  endfunction

  function automatic logic mode_has_wr(input logic [1:0] m);
    return (m == MODE_WR) || (m == MODE_COPY);
  endfunction

endpackage

// File: rtl/axil_word_buf.sv
// DEPTH x DATA_W word buffer: one synchronous write port, two combinational
// read ports (one feeds AXI write data, one is the user read-back port).
module axil_word_buf #(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = 32,
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ra_idx,
  output logic [DATA_W-1:0] ra_data,
  input  logic [IDX_W-1:0]  rb_idx,
  output logic [DATA_W-1:0] rb_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset: contents survive areset by design.
  always_ff @(posedge clk) begin
    if (we && (int'(widx) < DEPTH)) mem[widx] <= wdata;
  end

  assign ra_data = (int'(ra_idx) < DEPTH) ? mem[ra_idx] : '0;
  assign rb_data = (int'(rb_idx) < DEPTH) ? mem[rb_idx] : '0;

endmodule

// File: rtl/axil_burst_master.sv
// AXI4-Lite master moving up to DEPTH words between a local buffer and memory
// (write, read, or read-then-write copy). Define AXIL_MST_ERR_STOP_EN to abort on error.
module axil_burst_master
  import axil_burst_pkg::*;
#(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              wbuf_we,
  input  logic [IDX_W-1:0]  wbuf_idx,
  input  logic [DATA_W-1:0] wbuf_data,
  input  logic [IDX_W-1:0]  rbuf_idx,
  output logic [DATA_W-1:0] rbuf_data,
  output logic              busy,
  output logic              wr_done,
  output logic              rd_done,
  output logic              err,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [DATA_W-1:0] m_wdata,
  output logic [STRB_W-1:0] m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready
);

`ifdef AXIL_MST_ERR_STOP_EN
  localparam bit ERR_STOP = 1'b1;
`else
  localparam bit ERR_STOP = 1'b0;
`endif
  localparam int BSH = $clog2(STRB_W);

  typedef struct packed {
    logic [1:0]        mode;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [CNT_W-1:0]  cnt;
  } cmd_t;

  state_t            state, state_nxt;
  cmd_t              cmd;
  logic [CNT_W-1:0]  idx, cnt_in;
  logic              aw_pend, w_pend;
  logic              accept, last, stop_r, stop_b, r_bad, b_bad, aw_ok, w_ok;
  logic              buf_we;
  logic [IDX_W-1:0]  buf_widx;
  logic [DATA_W-1:0] buf_wdata, buf_rdata;

  assign cnt_in = (count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : count;
  assign accept = start && (state == ST_IDLE) && (mode != MODE_NOP);
  assign last   = (idx == cmd.cnt - CNT_W'(1));
  assign r_bad  = (m_rresp != RESP_OKAY);
  assign b_bad  = (m_bresp != RESP_OKAY);
  assign stop_r = ERR_STOP && r_bad;
  assign stop_b = ERR_STOP && b_bad;
  // Each write channel completes independently; leave AW_W once both have.
  assign aw_ok  = !aw_pend || m_awready;
  assign w_ok   = !w_pend || m_wready;

  // Address/data derive only from latched command, idx and buffer, all frozen while waiting on ready.
  assign m_araddr = cmd.rd_addr + (ADDR_W'(idx) << BSH);
  assign m_awaddr = cmd.wr_addr + (ADDR_W'(idx) << BSH);
  assign m_wdata  = buf_rdata;
  assign m_wstrb  = '1;

  axil_word_buf #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_buf (
    .clk    (aclk),
    .we     (buf_we),
    .widx   (buf_widx),
    .wdata  (buf_wdata),
    .ra_idx (IDX_W'(idx)),
    .ra_data(buf_rdata),
    .rb_idx (rbuf_idx),
    .rb_data(rbuf_data)
  );

  always_ff @(posedge aclk) begin
    if (areset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) begin
        if (cnt_in == '0)          state_nxt = ST_DONE;
        else if (mode == MODE_WR)  state_nxt = ST_AW_W;
        else                       state_nxt = ST_AR;
      end
      ST_AR:   if (m_arready) state_nxt = ST_R;
      ST_R:    if (m_rvalid) begin
        if (stop_r)    state_nxt = ST_DONE;
        else if (last) state_nxt = (cmd.mode == MODE_COPY) ? ST_AW_W : ST_DONE;
        else           state_nxt = ST_AR;
      end
      ST_AW_W: if (aw_ok && w_ok) state_nxt = ST_B;
      ST_B:    if (m_bvalid) state_nxt = (stop_b || last) ? ST_DONE : ST_AW_W;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    m_arvalid = (state == ST_AR);
    m_rready  = (state == ST_R);
    m_awvalid = (state == ST_AW_W) && aw_pend;
    m_wvalid  = (state == ST_AW_W) && w_pend;
    m_bready  = (state == ST_B);
    busy      = (state == ST_AR) || (state == ST_R) || (state == ST_AW_W) || (state == ST_B);
    buf_we    = wbuf_we && ((state == ST_IDLE) || (state == ST_DONE));
    buf_widx  = wbuf_idx;
    buf_wdata = wbuf_data;
    if ((state == ST_R) && m_rvalid) begin
      buf_we    = 1'b1;
      buf_widx  = IDX_W'(idx);
      buf_wdata = m_rdata;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      cmd     <= '0;
      idx     <= '0;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      wr_done <= 1'b0;
      rd_done <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          cmd     <= '{mode: mode, wr_addr: wr_addr, rd_addr: rd_addr, cnt: cnt_in};
          idx     <= '0;
          err     <= 1'b0;
          aw_pend <= (mode == MODE_WR) && (cnt_in != '0);
          w_pend  <= (mode == MODE_WR) && (cnt_in != '0);
          // A zero-length op completes immediately, so its flags go straight to set.
          if (mode_has_rd(mode)) rd_done <= (cnt_in == '0);
          if (mode_has_wr(mode)) wr_done <= (cnt_in == '0);
        end
        ST_R: if (m_rvalid) begin
          if (r_bad) err <= 1'b1;
          if (stop_r || last) begin
            rd_done <= 1'b1;
            if (!stop_r && (cmd.mode == MODE_COPY)) begin
              idx     <= '0;
              aw_pend <= 1'b1;
              w_pend  <= 1'b1;
            end
          end else begin
            idx <= idx + CNT_W'(1);
          end
        end
        ST_AW_W: begin
          if (m_awready) aw_pend <= 1'b0;
          if (m_wready)  w_pend  <= 1'b0;
        end
        ST_B: if (m_bvalid) begin
          if (b_bad) err <= 1'b1;
          if (stop_b || last) begin
            wr_done <= 1'b1;
          end else begin
            idx     <= idx + CNT_W'(1);
            aw_pend <= 1'b1;
            w_pend  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_burst_master.sv
// Bench for axil_burst_master: randomized-stall AXI-Lite slave with memory,
// scoreboard queues filled per command from a word-level reference model.
module tb_axil_burst_master;
  import axil_burst_pkg::*;

  localparam int DEPTH = 4;
`ifdef AXIL_MST_ERR_STOP_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic        aclk, areset, start, wbuf_we;
  logic [1:0]  mode;
  logic [31:0] wr_addr, rd_addr, wbuf_data, rbuf_data;
  logic [2:0]  count;
  logic [1:0]  wbuf_idx, rbuf_idx;
  logic        busy, wr_done, rd_done, err;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0]  m_bresp, m_rresp;

  axil_burst_master #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (
    .aclk(aclk), .areset(areset), .start(start), .mode(mode),
    .wr_addr(wr_addr), .rd_addr(rd_addr), .count(count),
    .wbuf_we(wbuf_we), .wbuf_idx(wbuf_idx), .wbuf_data(wbuf_data),
    .rbuf_idx(rbuf_idx), .rbuf_data(rbuf_data),
    .busy(busy), .wr_done(wr_done), .rd_done(rd_done), .err(err),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

  int tests = 0, fails = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] bufm [DEPTH];
  wr_t         exp_wr [$];
  logic [31:0] exp_ar [$];
  bit          stall_en = 0, b_hold = 0;
  int          err_at_r = -1, err_at_b = -1, r_seen = 0, b_seen = 0;
  int          ar_cnt = 0, aw_cnt = 0;
  bit          rd_f = 0, wr_f = 0;

  // slave-side state
  bit          r_pend, b_pend, got_aw, got_w, p_aw, p_w, p_ar;
  int          r_wait, b_wait, aw_wait, w_wait, ar_wait;
  logic [31:0] r_addr, b_addr, b_data, p_awaddr, p_wdata, p_araddr;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic flag_fail(input string nm, input logic [31:0] act);
    tests++;
    fails++;
    $display("FAIL %s: got request %0h, required none", nm, act);
  endtask

  function automatic int stall();
    return stall_en ? int'($urandom_range(0, 7)) : 0;
  endfunction

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // Slave + monitor: at each negedge decide the inputs seen at the next
  // posedge, then account for the handshakes that posedge will complete.
  always @(negedge aclk) begin
    if (areset) begin
      m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
      m_bresp = 0; m_rresp = 0; m_rdata = 0;
      r_pend = 0; b_pend = 0; got_aw = 0; got_w = 0; p_aw = 0; p_w = 0; p_ar = 0;
      r_wait = 0; b_wait = 0; aw_wait = 0; w_wait = 0; ar_wait = 0;
    end else begin
      if (p_aw) check("aw_hold", {31'd0, m_awvalid, m_awaddr}, {31'd0, 1'b1, p_awaddr});
      if (p_w)  check("w_hold",  {31'd0, m_wvalid, m_wdata},   {31'd0, 1'b1, p_wdata});
      if (p_ar) check("ar_hold", {31'd0, m_arvalid, m_araddr}, {31'd0, 1'b1, p_araddr});
      m_rvalid = 0;
      if (r_pend) begin
        if (r_wait == 0) begin
          m_rvalid = 1; m_rdata = rd_mem(r_addr);
          m_rresp = (r_seen == err_at_r) ? 2'b10 : 2'b00;
        end else r_wait--;
      end
      if (m_rvalid && m_rready) begin r_pend = 0; r_seen++; end
      m_arready = 0;
      if (m_arvalid && !r_pend) begin
        if (ar_wait == 0) m_arready = 1; else ar_wait--;
      end
      if (m_arvalid && m_arready) begin
        if (exp_ar.size() == 0) flag_fail("ar_unexpected", m_araddr);
        else check("ar_addr", {32'd0, m_araddr}, {32'd0, exp_ar.pop_front()});
        r_pend = 1; r_addr = m_araddr; r_wait = stall(); ar_wait = stall(); ar_cnt++;
      end
      p_ar = m_arvalid && !m_arready; p_araddr = m_araddr;
      m_bvalid = 0;
      if (b_pend && !b_hold) begin
        if (b_wait == 0) begin
          m_bvalid = 1; m_bresp = (b_seen == err_at_b) ? 2'b10 : 2'b00;
        end else b_wait--;
      end
      if (m_bvalid && m_bready) begin b_pend = 0; b_seen++; mem[b_addr] = b_data; end
      m_awready = 0;
      if (m_awvalid && !got_aw && !b_pend) begin
        if (aw_wait == 0) m_awready = 1; else aw_wait--;
      end
      if (m_awvalid && m_awready) begin
        got_aw = 1; b_addr = m_awaddr; aw_wait = stall(); aw_cnt++;
      end
      m_wready = 0;
      if (m_wvalid && !got_w && !b_pend) begin
        if (w_wait == 0) m_wready = 1; else w_wait--;
      end
      if (m_wvalid && m_wready) begin
        got_w = 1; b_data = m_wdata; w_wait = stall();
        check("wstrb", {60'd0, m_wstrb}, {60'd0, 4'hF});
      end
      p_aw = m_awvalid && !m_awready; p_awaddr = m_awaddr;
      p_w  = m_wvalid && !m_wready;   p_wdata  = m_wdata;
      if (got_aw && got_w) begin
        if (exp_wr.size() == 0) flag_fail("wr_unexpected", b_addr);
        else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("wr_beat", {b_addr, b_data}, {e.addr, e.data});
        end
        b_pend = 1; b_wait = stall(); got_aw = 0; got_w = 0;
      end
    end
  end

  task automatic load_word(input int k, input logic [31:0] d);
    @(negedge aclk);
    wbuf_we = 1; wbuf_idx = 2'(k); wbuf_data = d;
    @(negedge aclk);
    wbuf_we = 0;
    bufm[k] = d;
  endtask

  task automatic run_op(input string nm, input logic [1:0] md, input logic [31:0] wa,
                        input logic [31:0] ra, input logic [2:0] cnt,
                        input bit pulse_busy, input bit ld0, input logic [31:0] ld0_val);
    int  n, n_rd, n_wr, ar0, aw0, budget;
    bit  has_rd, has_wr, rd_stop, do_wr, wr_stop, exp_err;
    n       = (int'(cnt) > DEPTH) ? DEPTH : int'(cnt);
    has_rd  = (md == MODE_RD) || (md == MODE_COPY);
    has_wr  = (md == MODE_WR) || (md == MODE_COPY);
    rd_stop = STOP && has_rd && (err_at_r >= 0) && (err_at_r < n);
    n_rd    = has_rd ? (rd_stop ? err_at_r + 1 : n) : 0;
    do_wr   = has_wr && !rd_stop;
    wr_stop = STOP && do_wr && (err_at_b >= 0) && (err_at_b < n);
    n_wr    = do_wr ? (wr_stop ? err_at_b + 1 : n) : 0;
    exp_err = (has_rd && (err_at_r >= 0) && (err_at_r < n)) ||
              (do_wr && (err_at_b >= 0) && (err_at_b < n));
    if (has_rd) rd_f = 1;
    if (has_wr) wr_f = do_wr;
    if (ld0) bufm[0] = ld0_val;
    for (int k = 0; k < n_rd; k++) begin
      exp_ar.push_back(ra + 32'(4 * k));
      bufm[k] = rd_mem(ra + 32'(4 * k));
    end
    for (int k = 0; k < n_wr; k++) exp_wr.push_back('{wa + 32'(4 * k), bufm[k]});
    r_seen = 0; b_seen = 0; ar0 = ar_cnt; aw0 = aw_cnt;
    @(negedge aclk);
    start = 1; mode = md; wr_addr = wa; rd_addr = ra; count = cnt;
    if (ld0) begin wbuf_we = 1; wbuf_idx = 0; wbuf_data = ld0_val; end
    @(negedge aclk);
    wbuf_we = 0;
    if (pulse_busy) begin
      mode = MODE_WR; wr_addr = 32'h1234_0000; count = 3'd1;
      @(negedge aclk);
    end
    start = 0;
    budget = 0;
    while (busy && budget < 3000) begin @(negedge aclk); budget++; end
    if (budget >= 3000) begin
      tests++; fails++;
      $display("FAIL %s_timeout: busy still %0b after %0d cycles, required 0", nm, busy, budget);
    end
    check({nm, "_flags"}, {61'd0, rd_done, wr_done, err}, {61'd0, rd_f, wr_f, exp_err});
    check({nm, "_left"}, 64'(exp_wr.size() + exp_ar.size()), 64'd0);
    check({nm, "_ntx"}, {32'(ar_cnt - ar0), 32'(aw_cnt - aw0)}, {32'(n_rd), 32'(n_wr)});
    if (!exp_err) begin
      for (int k = 0; k < n_wr; k++)
        check({nm, "_mem"}, {32'd0, rd_mem(wa + 32'(4 * k))}, {32'd0, bufm[k]});
      for (int k = 0; k < n_rd; k++) begin
        rbuf_idx = 2'(k); #1;
        check({nm, "_rbuf"}, {32'd0, rbuf_data}, {32'd0, bufm[k]});
      end
    end
    exp_wr.delete(); exp_ar.delete();
    err_at_r = -1; err_at_b = -1;
    @(negedge aclk);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int budget, ar0, aw0;
    logic [1:0] md;
    areset = 1; start = 0; mode = 0; wr_addr = 0; rd_addr = 0; count = 0;
    wbuf_we = 0; wbuf_idx = 0; wbuf_data = 0; rbuf_idx = 0;
    repeat (3) @(negedge aclk);
    check("rst_ctrl", {55'd0, busy, wr_done, rd_done, err, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 64'd0);
    check("rst_addr", {m_awaddr, m_araddr}, 64'd0);
    areset = 0;
    @(negedge aclk);

    load_word(0, 32'h0123_4567); load_word(1, 32'h89AB_CDEF);
    load_word(2, 32'h7654_3210); load_word(3, 32'hFEDC_BA98);
    run_op("wr4", MODE_WR, 32'hC000_0000, 32'h0, 3'd4, 0, 0, 32'h0);
    for (int k = 0; k < DEPTH; k++) load_word(k, 32'h0);
    run_op("rd4", MODE_RD, 32'h0, 32'hC000_0000, 3'd4, 0, 0, 32'h0);
    run_op("copy4", MODE_COPY, 32'hC000_0004, 32'hC000_0000, 3'd4, 0, 0, 32'h0);

    stall_en = 1;
    for (int it = 0; it < 6; it++) begin
      md = 2'($urandom_range(1, 3));
      for (int k = 0; k < DEPTH; k++) load_word(k, $urandom);
      run_op("rand", md, 32'h8000_0000 + 32'($urandom_range(0, 255) << 4),
             32'h9000_0000 + 32'($urandom_range(0, 255) << 4), 3'(DEPTH), 0, 0, 32'h0);
    end

    err_at_r = 1;
    run_op("rderr", MODE_RD, 32'h0, 32'hA000_0000, 3'd4, 0, 0, 32'h0);
    err_at_b = 1;
    run_op("wrerr", MODE_WR, 32'hA100_0000, 32'h0, 3'd4, 0, 0, 32'h0);
    err_at_r = 1;
    run_op("cperr", MODE_COPY, 32'hA200_0000, 32'hA300_0000, 3'd4, 0, 0, 32'h0);

    run_op("cnt0w", MODE_WR, 32'hB100_0000, 32'h0, 3'd0, 0, 0, 32'h0);
    run_op("cnt0r", MODE_RD, 32'h0, 32'hB200_0000, 3'd0, 0, 0, 32'h0);
    run_op("clamp", MODE_WR, 32'hB300_0000, 32'h0, 3'd7, 0, 1, 32'hCAFE_F00D);
    run_op("busyst", MODE_RD, 32'h0, 32'hB400_0000, 3'd4, 1, 0, 32'h0);

    ar0 = ar_cnt; aw0 = aw_cnt;
    @(negedge aclk);
    start = 1; mode = MODE_NOP; count = 3'd4;
    @(negedge aclk);
    start = 0;
    repeat (4) @(negedge aclk);
    check("nop_state", {32'(ar_cnt - ar0), 29'd0, busy, rd_done, wr_done}, {32'd0, 29'd0, 1'b0, rd_f, wr_f});
    check("nop_aw", 64'(aw_cnt - aw0), 64'd0);

    b_hold = 1;
    exp_wr.push_back('{32'hB500_0000, bufm[0]});
    @(negedge aclk);
    start = 1; mode = MODE_WR; wr_addr = 32'hB500_0000; count = 3'd1;
    @(negedge aclk);
    start = 0;
    budget = 0;
    while (!m_bready && budget < 200) begin @(negedge aclk); budget++; end
    check("rstb_inb", {63'd0, m_bready}, 64'd1);
    areset = 1;
    @(negedge aclk);
    check("rstb_ctrl", {55'd0, busy, wr_done, rd_done, err, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 64'd0);
    check("rstb_addr", {m_awaddr, m_araddr}, 64'd0);
    areset = 0; b_hold = 0; rd_f = 0; wr_f = 0;
    exp_wr.delete(); exp_ar.delete();
    @(negedge aclk);
    for (int k = 0; k < DEPTH; k++) begin
      rbuf_idx = 2'(k); #1;
      check("rstb_keep", {32'd0, rbuf_data}, {32'd0, bufm[k]});
    end
    run_op("post", MODE_WR, 32'hB600_0000, 32'h0, 3'd2, 0, 0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
